// File: rtl/seq_pkg.sv
// Shared definitions for the sequence-memory game controller.
package seq_pkg;

  localparam int         MAX_LEVEL = 16;
  localparam logic [3:0] LED_ALL   = 4'b1111;
  localparam logic [3:0] LED_OFF   = 4'b0000;

  // State encoding kept as plain constants for legacy tool flows.
  typedef logic [2:0] state_t;

  localparam state_t S_IDLE     = 3'd0;
  localparam state_t S_SHOW_ON  = 3'd1;
  localparam state_t S_SHOW_OFF = 3'd2;
  localparam state_t S_WAIT_IN  = 3'd3;
  localparam state_t S_PAUSE    = 3'd4;
  localparam state_t S_WIN      = 3'd5;
  localparam state_t S_LOSE     = 3'd6;

endpackage

// File: rtl/seq_timer.sv
// Loadable down-counter. done_o pulses for one cycle when a loaded count
// has run down to zero; it stays low while the counter idles at zero.
module seq_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         armed_q, armed_d;

  // Next count: load wins, otherwise run down and disarm at terminal count.
  always_comb begin
    cnt_d   = cnt_q;
    armed_d = armed_q;
    if (load_i) begin
      cnt_d   = val_i;
      armed_d = 1'b1;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end else begin
      armed_d = 1'b0;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
    end
  end

  assign done_o = armed_q && (cnt_q == '0);

endmodule

// File: rtl/seq_ctrl.sv
// Sequence-memory game controller: plays back a growing LED sequence read
// from an external ROM, then checks the player's button presses against it.
// Optional feature macro: SEQ_TIMEOUT_EN (player idle limit in WAIT_IN).
//
// state    | meaning
// ---------+--------------------------------------------------
// IDLE     | after reset, waiting for start
// SHOW_ON  | LED of step idx lit for ON_CYCLES
// SHOW_OFF | dark gap of OFF_CYCLES after each lit step
// WAIT_IN  | player reproduces the sequence, led echoes presses
// PAUSE    | OFF_CYCLES pause before playing the next level
// WIN      | all 16 levels done, all LEDs on, wait for start
// LOSE     | wrong press (or timeout), LEDs off, wait for start
module seq_ctrl
  import seq_pkg::*;
#(
  parameter int ON_CYCLES      = 50,
  parameter int OFF_CYCLES     = 25,
  parameter int TIMEOUT_CYCLES = 500
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] btn,
  input  logic       btn_valid,
  output logic [3:0] rom_addr,
  input  logic [3:0] rom_data,
  output logic [3:0] led,
  output logic [4:0] level,
  output logic       player_turn,
  output logic       win,
  output logic       lose
);

  if (ON_CYCLES < 1 || OFF_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("seq_ctrl: cycle parameters must be at least 1");
  end

  localparam int SHOW_MAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
`ifdef SEQ_TIMEOUT_EN
  localparam int CNT_MAX  = (SHOW_MAX > TIMEOUT_CYCLES) ? SHOW_MAX : TIMEOUT_CYCLES;
`else
  localparam int CNT_MAX  = SHOW_MAX;
`endif
  localparam int TW = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

  // Timers are loaded with N-1 on entry so a state lasts exactly N cycles.
  localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LOAD = TW'(OFF_CYCLES - 1);
`ifdef SEQ_TIMEOUT_EN
  localparam logic [TW-1:0] TO_LOAD  = TW'(TIMEOUT_CYCLES - 1);
`endif

  state_t        state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [4:0]    level_q, level_d;
  logic [3:0]    echo_q, echo_d;
  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_done;
  logic          last_step;

  seq_timer #(.W(TW)) u_timer (
    .clk    (clk),
    .rst    (reset),
    .load_i (tmr_load),
    .val_i  (tmr_val),
    .done_o (tmr_done)
  );

  assign last_step = ({1'b0, idx_q} == (level_q - 5'd1));

  // Next-state, step/level bookkeeping and timer loads.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    level_d  = level_q;
    echo_d   = echo_q;
    tmr_load = 1'b0;
    tmr_val  = ON_LOAD;
    case (state_q)
      S_IDLE, S_WIN, S_LOSE: begin
        if (start) begin
          state_d  = S_SHOW_ON;
          level_d  = 5'd1;
          idx_d    = 4'd0;
          echo_d   = LED_OFF;
          tmr_load = 1'b1;
          tmr_val  = ON_LOAD;
        end
      end
      S_SHOW_ON: begin
        if (tmr_done) begin
          state_d  = S_SHOW_OFF;
          tmr_load = 1'b1;
          tmr_val  = OFF_LOAD;
        end
      end
      S_SHOW_OFF: begin
        if (tmr_done) begin
          if (last_step) begin
            state_d = S_WAIT_IN;
            idx_d   = 4'd0;
            echo_d  = LED_OFF;
`ifdef SEQ_TIMEOUT_EN
            tmr_load = 1'b1;
            tmr_val  = TO_LOAD;
`endif
          end else begin
            state_d  = S_SHOW_ON;
            idx_d    = idx_q + 4'd1;
            tmr_load = 1'b1;
            tmr_val  = ON_LOAD;
          end
        end
      end
      S_WAIT_IN: begin
        if (btn_valid) begin
          if (btn == rom_data) begin
            echo_d = btn;
            if (!last_step) begin
              idx_d = idx_q + 4'd1;
`ifdef SEQ_TIMEOUT_EN
              tmr_load = 1'b1;
              tmr_val  = TO_LOAD;
`endif
            end else if (level_q < 5'(MAX_LEVEL)) begin
              state_d  = S_PAUSE;
              level_d  = level_q + 5'd1;
              idx_d    = 4'd0;
              tmr_load = 1'b1;
              tmr_val  = OFF_LOAD;
            end else begin
              state_d = S_WIN;
            end
          end else begin
            state_d = S_LOSE;
          end
        end
`ifdef SEQ_TIMEOUT_EN
        else if (tmr_done) begin
          state_d = S_LOSE;
        end
`endif
      end
      S_PAUSE: begin
        if (tmr_done) begin
          state_d  = S_SHOW_ON;
          tmr_load = 1'b1;
          tmr_val  = ON_LOAD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and game registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= 4'd0;
      level_q <= 5'd1;
      echo_q  <= LED_OFF;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      level_q <= level_d;
      echo_q  <= echo_d;
    end
  end

  // LED drive decoded from the registered state.
  always_comb begin
    led = LED_OFF;
    case (state_q)
      S_SHOW_ON: led = rom_data;
      S_WAIT_IN: led = echo_q;
      S_WIN:     led = LED_ALL;
      default:   led = LED_OFF;
    endcase
  end

  assign rom_addr    = idx_q;
  assign level       = level_q;
  assign player_turn = (state_q == S_WAIT_IN);
  assign win         = (state_q == S_WIN);
  assign lose        = (state_q == S_LOSE);

endmodule

// File: tb/tb_seq_ctrl.sv
// Directed bench for seq_ctrl with a small fixed ROM and short intervals.
// Builds with or without SEQ_TIMEOUT_EN.
module tb_seq_ctrl;

  localparam int ON  = 4;
  localparam int OFF = 2;
  localparam int TO  = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] btn;
  logic       btn_valid;
  logic [3:0] rom_addr;
  logic [3:0] rom_data;
  logic [3:0] led;
  logic [4:0] level;
  logic       player_turn;
  logic       win;
  logic       lose;

  int n_cmp = 0;
  int n_err = 0;

  seq_ctrl #(
    .ON_CYCLES      (ON),
    .OFF_CYCLES     (OFF),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .btn         (btn),
    .btn_valid   (btn_valid),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .led         (led),
    .level       (level),
    .player_turn (player_turn),
    .win         (win),
    .lose        (lose)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] rom_f(input int a);
    case (a)
      0:       return 4'b0001;
      1:       return 4'b1000;
      2:       return 4'b0100;
      default: return 4'b0010;
    endcase
  endfunction

  always_comb rom_data = rom_f(int'(rom_addr));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic press(input logic [3:0] b);
    btn       = b;
    btn_valid = 1'b1;
    tick();
    btn_valid = 1'b0;
    btn       = 4'b0000;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_led"},   32'(led), 32'h0);
    chk({tag, "_level"}, 32'(level), 32'd1);
    chk({tag, "_addr"},  32'(rom_addr), 32'd0);
    chk({tag, "_turn"},  32'(player_turn), 32'd0);
    chk({tag, "_win"},   32'(win), 32'd0);
    chk({tag, "_lose"},  32'(lose), 32'd0);
  endtask

  // Starts in the first SHOW_ON cycle, ends in the first WAIT_IN cycle.
  task automatic play_check(input int lvl);
    for (int s = 0; s < lvl; s++) begin
      for (int c = 0; c < ON; c++) begin
        chk("show_led", 32'(led), 32'(rom_f(s)));
        chk("show_turn", 32'(player_turn), 32'd0);
        tick();
      end
      for (int c = 0; c < OFF; c++) begin
        chk("gap_led", 32'(led), 32'h0);
        tick();
      end
    end
    chk("wait_turn", 32'(player_turn), 32'd1);
    chk("wait_led", 32'(led), 32'h0);
    chk("wait_level", 32'(level), 32'(lvl));
    chk("wait_addr", 32'(rom_addr), 32'd0);
  endtask

  // Starts in the first PAUSE cycle, ends in the first SHOW_ON cycle.
  task automatic pause_check(input int new_lvl);
    for (int c = 0; c < OFF; c++) begin
      chk("pause_led", 32'(led), 32'h0);
      chk("pause_turn", 32'(player_turn), 32'd0);
      chk("pause_level", 32'(level), 32'(new_lvl));
      tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    btn       = 4'b0000;
    btn_valid = 1'b0;
    tick();
    tick();
    chk_reset_vals("rst");
    reset = 1'b0;
    tick();

    // No action before start, even with button strobes.
    press(4'b0001);
    tick();
    chk_reset_vals("pre_start");

    // Level 1 playback and correct press.
    pulse_start();
    chk("l1_addr", 32'(rom_addr), 32'd0);
    play_check(1);
    press(4'b0001);
    pause_check(2);

    // Level 2: correct then wrong press.
    play_check(2);
    press(4'b0001);
    chk("echo_led", 32'(led), 32'h1);
    chk("echo_turn", 32'(player_turn), 32'd1);
    chk("echo_addr", 32'(rom_addr), 32'd1);
    press(4'b0100);
    chk("lose_flag", 32'(lose), 32'd1);
    chk("lose_led", 32'(led), 32'h0);
    chk("lose_turn", 32'(player_turn), 32'd0);
    tick();
    chk("lose_hold", 32'(lose), 32'd1);

    // Restart from LOSE, then reset during the second SHOW_ON of level 2.
    pulse_start();
    chk("restart_level", 32'(level), 32'd1);
    chk("restart_lose", 32'(lose), 32'd0);
    play_check(1);
    press(4'b0001);
    pause_check(2);
    for (int c = 0; c < ON + OFF + 1; c++) tick();
    chk("pre_rst_led", 32'(led), 32'h8);
    reset = 1'b1;
    tick();
    chk_reset_vals("mid_rst");
    reset = 1'b0;
    tick();
    press(4'b0001);
    press(4'b1000);
    tick();
    chk_reset_vals("post_rst");

    // Wrong press with btn=0 in WAIT_IN.
    pulse_start();
    play_check(1);
    press(4'b0000);
    chk("zero_btn_lose", 32'(lose), 32'd1);

    // Multi-hot press loses too.
    pulse_start();
    play_check(1);
    press(4'b0011);
    chk("multi_btn_lose", 32'(lose), 32'd1);

    // Full game through level 16.
    pulse_start();
    for (int lv = 1; lv <= 16; lv++) begin
      play_check(lv);
      for (int i = 0; i < lv; i++) begin
        press(rom_f(i));
        if (i < lv - 1) begin
          chk("step_echo", 32'(led), 32'(rom_f(i)));
          chk("step_turn", 32'(player_turn), 32'd1);
        end
      end
      if (lv < 16) pause_check(lv + 1);
    end
    chk("win_flag", 32'(win), 32'd1);
    chk("win_led", 32'(led), 32'hF);
    chk("win_level", 32'(level), 32'd16);
    press(4'b0001);
    press(4'b0010);
    tick();
    chk("win_hold", 32'(win), 32'd1);
    chk("win_hold_led", 32'(led), 32'hF);
    chk("win_hold_lose", 32'(lose), 32'd0);

    // Idle player in WAIT_IN.
    pulse_start();
    chk("win_restart", 32'(win), 32'd0);
    play_check(1);
`ifdef SEQ_TIMEOUT_EN
    for (int c = 0; c < TO - 1; c++) tick();
    chk("to_not_yet", 32'(player_turn), 32'd1);
    chk("to_not_yet_lose", 32'(lose), 32'd0);
    tick();
    chk("to_lose", 32'(lose), 32'd1);
    chk("to_turn", 32'(player_turn), 32'd0);
`else
    for (int c = 0; c < 1000; c++) tick();
    chk("no_to_turn", 32'(player_turn), 32'd1);
    chk("no_to_lose", 32'(lose), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seq_ctrl.md
SEQ_CTRL -- requirements
Module: seq_ctrl

Interface
REQ-001 Parameter ON_CYCLES, default 50: cycles each sequence LED is lit during playback.
REQ-002 Parameter OFF_CYCLES, default 25: dark gap cycles after each lit step, and the pause before a new level.
REQ-003 Parameter TIMEOUT_CYCLES, default 500: player idle limit; used only when SEQ_TIMEOUT_EN is defined.
REQ-004 clk  in  1  single system clock, rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  single-cycle pulse that begins a new game.
REQ-007 btn  in  4  player button code, one-hot expected, sampled only when btn_valid=1.
REQ-008 btn_valid  in  1  single-cycle strobe qualifying btn (already debounced and synchronized upstream).
REQ-009 rom_addr  out  4  step index presented to the external sequence ROM.
REQ-010 rom_data  in  4  one-hot ROM word for rom_addr, combinational, same cycle.
REQ-011 led  out  4  LED drive.
REQ-012 level  out  5  current level, 1..16.
REQ-013 player_turn  out  1  high while awaiting player input.
REQ-014 win, lose  out  1 each  game-result flags.

Function
REQ-015 The FSM SHALL have the states IDLE, SHOW_ON, SHOW_OFF, WAIT_IN, PAUSE, WIN and LOSE.
REQ-016 IDLE: led=0; start moves to SHOW_ON with level=1 and step index idx=0.
REQ-017 SHOW_ON: rom_addr=idx and led=rom_data for exactly ON_CYCLES cycles, then SHOW_OFF.
REQ-018 SHOW_OFF: led=0 for exactly OFF_CYCLES cycles; then, if idx==level-1, idx clears and the FSM enters WAIT_IN; otherwise idx increments and the FSM returns to SHOW_ON.
REQ-019 WAIT_IN: player_turn=1, rom_addr=idx, led=btn echo of the last accepted press (0 on entry).
REQ-020 WAIT_IN with btn_valid and btn==rom_data: if idx<level-1, idx increments; if idx==level-1 and level<16, level increments, idx clears and the FSM enters PAUSE; if idx==level-1 and level==16, the FSM enters WIN.
REQ-021 WAIT_IN with btn_valid and btn!=rom_data: the FSM enters LOSE; this includes btn=0 and multi-hot codes.
REQ-022 PAUSE: led=0 for OFF_CYCLES cycles, then SHOW_ON.
REQ-023 WIN: win=1, led=4'b1111. LOSE: lose=1, led=4'b0000. Both states hold until start, which restarts exactly as from IDLE.
REQ-024 A start pulse in any state other than IDLE, WIN or LOSE SHALL be ignored.
REQ-025 btn_valid outside WAIT_IN SHALL be ignored.
REQ-026 State changes occur on the clk edge that samples the triggering input; outputs reflect the new state in the following cycle.
REQ-027 level SHALL never exceed 16 and idx SHALL never exceed level-1; rom_addr is idx truncated to 4 bits.

Reset
REQ-028 Asserting reset at any time, including mid-playback or mid-input, SHALL immediately force IDLE, idx=0, level=1, led=0, rom_addr=0, player_turn=0, win=0, lose=0 and the timer to 0.
REQ-029 After reset deasserts, no action SHALL occur until a start pulse.

Configuration
REQ-030 With SEQ_TIMEOUT_EN defined, WAIT_IN SHALL count cycles since entry or since the last accepted press, and reaching TIMEOUT_CYCLES without btn_valid SHALL enter LOSE.
REQ-031 Without SEQ_TIMEOUT_EN, WAIT_IN SHALL wait indefinitely, and neither the timeout logic nor the TIMEOUT_CYCLES comparison SHALL be present.

Structure
REQ-032 Shared package seq_pkg SHALL hold the state encoding typedef, MAX_LEVEL=16, LED_ALL=4'b1111 and LED_OFF=4'b0000.
REQ-033 Sub-module seq_timer: a loadable down-counter with a done pulse, reused for the ON, OFF, PAUSE and timeout intervals.

Verification (bench ROM: addr0=0001, addr1=1000, addr2=0100, others=0010; ON_CYCLES=4, OFF_CYCLES=2, TIMEOUT_CYCLES=20)
REQ-034 start -> led=0001 for 4 cycles, then 0 for 2 cycles, then player_turn=1 with level=1.
REQ-035 Level 1: press btn=0001 -> PAUSE 2 cycles, level=2, playback shows 0001 then 1000.
REQ-036 Level 2: press 0001 then 0100 -> lose=1, led=0; a subsequent start gives level=1 with playback restarting at addr0.
REQ-037 Assert reset during the second SHOW_ON of level 2 -> all outputs at reset values on the next cycle; btn_valid pulses are ignored until start.
REQ-038 Correct inputs through level 16 -> win=1, led=1111, level=16; btn_valid pulses in WIN have no effect.
REQ-039 SEQ_TIMEOUT_EN defined: no press for 20 cycles in WAIT_IN -> lose=1; undefined: player_turn stays 1 after 1000 idle cycles.
